// File: rtl/nwcc_gate_ctrl.sv
// nwcc_gate_ctrl: slices free-running coincidence accumulators into back-to-back gates
// and hands one result set per gate to readout over valid/ready. Option macro: NWCC_REALS_SAT_EN.
`default_nettype none

module nwcc_gate_ctrl #(
    parameter int DATA_BITS = 24,
    parameter int GATE_BITS = 20,
    parameter int CYC_BITS  = 8
) (
    input  logic                 i_clk_1mhz,
    input  logic                 i_reset_n,
    input  logic [DATA_BITS-1:0] i_total_count,
    input  logic [DATA_BITS-1:0] i_r_plus_a_count,
    input  logic [DATA_BITS-1:0] i_a_count,
    input  logic [GATE_BITS-1:0] i_gate_len,
    input  logic [CYC_BITS-1:0]  i_num_cycles,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_res_total,
    output logic [DATA_BITS-1:0] o_res_r_plus_a,
    output logic [DATA_BITS-1:0] o_res_a,
    output logic [DATA_BITS-1:0] o_res_reals,
    output logic [CYC_BITS-1:0]  o_res_idx,
    output logic                 o_busy,
    output logic                 o_overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [GATE_BITS-1:0] len_q, len_d;
    logic [GATE_BITS-1:0] cnt_q, cnt_d;
    logic [CYC_BITS-1:0]  ncyc_q, ncyc_d;
    logic [CYC_BITS-1:0]  idx_q, idx_d;
    logic [DATA_BITS-1:0] snap_total_q, snap_total_d;
    logic [DATA_BITS-1:0] snap_rpa_q, snap_rpa_d;
    logic [DATA_BITS-1:0] snap_a_q, snap_a_d;
    logic                 pend_q, pend_d;
    logic [DATA_BITS-1:0] pend_total_q, pend_total_d;
    logic [DATA_BITS-1:0] pend_rpa_q, pend_rpa_d;
    logic [DATA_BITS-1:0] pend_a_q, pend_a_d;
    logic [CYC_BITS-1:0]  pend_idx_q, pend_idx_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] res_total_q, res_total_d;
    logic [DATA_BITS-1:0] res_rpa_q, res_rpa_d;
    logic [DATA_BITS-1:0] res_a_q, res_a_d;
    logic [CYC_BITS-1:0]  res_idx_q, res_idx_d;
    logic                 overrun_q, overrun_d;
    logic [GATE_BITS-1:0] w_start_len;

    assign w_start_len = (i_gate_len == '0) ? GATE_BITS'(1) : i_gate_len;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        ncyc_d       = ncyc_q;
        idx_d        = idx_q;
        snap_total_d = snap_total_q;
        snap_rpa_d   = snap_rpa_q;
        snap_a_d     = snap_a_q;
        pend_d       = 1'b0;
        pend_total_d = pend_total_q;
        pend_rpa_d   = pend_rpa_q;
        pend_a_d     = pend_a_q;
        pend_idx_d   = pend_idx_q;
        valid_d      = valid_q;
        res_total_d  = res_total_q;
        res_rpa_d    = res_rpa_q;
        res_a_d      = res_a_q;
        res_idx_d    = res_idx_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    snap_total_d = i_total_count;
                    snap_rpa_d   = i_r_plus_a_count;
                    snap_a_d     = i_a_count;
                    len_d        = w_start_len;
                    ncyc_d       = i_num_cycles;
                    cnt_d        = w_start_len - GATE_BITS'(1);
                    idx_d        = '0;
                    overrun_d    = 1'b0;
                    state_d      = ST_GATE;
                end
            end
            default: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    // The end snapshot doubles as the next gate's start, so gates tile without gaps.
                    pend_d       = 1'b1;
                    pend_total_d = i_total_count - snap_total_q;
                    pend_rpa_d   = i_r_plus_a_count - snap_rpa_q;
                    pend_a_d     = i_a_count - snap_a_q;
                    pend_idx_d   = idx_q;
                    snap_total_d = i_total_count;
                    snap_rpa_d   = i_r_plus_a_count;
                    snap_a_d     = i_a_count;
                    if ((ncyc_q != '0) && (idx_q == ncyc_q - CYC_BITS'(1))) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = len_q - GATE_BITS'(1);
                        idx_d = idx_q + CYC_BITS'(1);
                    end
                end else begin
                    cnt_d = cnt_q - GATE_BITS'(1);
                end
            end
        endcase

        // A pending result lands even if the run was stopped meanwhile.
        if (pend_q) begin
            if (!valid_q || i_ready) begin
                valid_d     = 1'b1;
                res_total_d = pend_total_q;
                res_rpa_d   = pend_rpa_q;
                res_a_d     = pend_a_q;
                res_idx_d   = pend_idx_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk_1mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            ncyc_q       <= '0;
            idx_q        <= '0;
            snap_total_q <= '0;
            snap_rpa_q   <= '0;
            snap_a_q     <= '0;
            pend_q       <= 1'b0;
            pend_total_q <= '0;
            pend_rpa_q   <= '0;
            pend_a_q     <= '0;
            pend_idx_q   <= '0;
            valid_q      <= 1'b0;
            res_total_q  <= '0;
            res_rpa_q    <= '0;
            res_a_q      <= '0;
            res_idx_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            ncyc_q       <= ncyc_d;
            idx_q        <= idx_d;
            snap_total_q <= snap_total_d;
            snap_rpa_q   <= snap_rpa_d;
            snap_a_q     <= snap_a_d;
            pend_q       <= pend_d;
            pend_total_q <= pend_total_d;
            pend_rpa_q   <= pend_rpa_d;
            pend_a_q     <= pend_a_d;
            pend_idx_q   <= pend_idx_d;
            valid_q      <= valid_d;
            res_total_q  <= res_total_d;
            res_rpa_q    <= res_rpa_d;
            res_a_q      <= res_a_d;
            res_idx_q    <= res_idx_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
`ifdef NWCC_REALS_SAT_EN
        o_res_reals = (res_a_q > res_rpa_q) ? '0 : (res_rpa_q - res_a_q);
`else
        o_res_reals = res_rpa_q - res_a_q;
`endif
    end

    assign o_valid        = valid_q;
    assign o_res_total    = res_total_q;
    assign o_res_r_plus_a = res_rpa_q;
    assign o_res_a        = res_a_q;
    assign o_res_idx      = res_idx_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_overrun      = overrun_q;

endmodule

`default_nettype wire
